// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage
//   ID/EX pipeline register plus operand-select stage feeding the ALU.
//   Latches the decoded instruction each cycle. Forwards rs1/rs2 from the
//   EX/MEM and MEM/WB stages. Selects the PC or immediate operands, and flags
//   load-use hazards. A bubble (flush or load-use) presents ADD 0+0 to the ALU.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   stall, flush               hold / kill the stage registers
//   id_*                       decoded fields of the instruction in ID
//   exmem_*, memwb_*           downstream writeback info used for forwarding
//   alu_in1, alu_in2, aluop    ALU operands and op code
//   ex_valid, ex_pc, ex_rd_addr, ex_regwrite, ex_memread, ex_store_data
//                              EX-slot instruction info
//   load_use_stall             request to hold IF/ID for one cycle
module id_ex_operand_stage #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  id_valid,
  input  logic [XLEN-1:0]       id_pc,
  input  logic [XLEN-1:0]       id_rs1_data,
  input  logic [XLEN-1:0]       id_rs2_data,
  input  logic [XLEN-1:0]       id_imm,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr,
  input  logic [REG_ADDR_W-1:0] id_rd_addr,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [3:0]            id_aluop,
  input  logic                  id_alusrc1,
  input  logic                  id_alusrc2,
  input  logic                  id_regwrite,
  input  logic                  id_memread,
  input  logic                  exmem_regwrite,
  input  logic [REG_ADDR_W-1:0] exmem_rd,
  input  logic [XLEN-1:0]       exmem_result,
  input  logic                  memwb_regwrite,
  input  logic [REG_ADDR_W-1:0] memwb_rd,
  input  logic [XLEN-1:0]       memwb_result,
  output logic [XLEN-1:0]       alu_in1,
  output logic [XLEN-1:0]       alu_in2,
  output logic [3:0]            aluop,
  output logic                  ex_valid,
  output logic [XLEN-1:0]       ex_pc,
  output logic [REG_ADDR_W-1:0] ex_rd_addr,
  output logic                  ex_regwrite,
  output logic                  ex_memread,
  output logic [XLEN-1:0]       ex_store_data,
  output logic                  load_use_stall
);

  logic                  valid_q,    valid_d;
  logic [XLEN-1:0]       pc_q,       pc_d;
  logic [XLEN-1:0]       rs1_data_q, rs1_data_d;
  logic [XLEN-1:0]       rs2_data_q, rs2_data_d;
  logic [XLEN-1:0]       imm_q,      imm_d;
  logic [REG_ADDR_W-1:0] rs1_addr_q, rs1_addr_d;
  logic [REG_ADDR_W-1:0] rs2_addr_q, rs2_addr_d;
  logic [REG_ADDR_W-1:0] rd_addr_q,  rd_addr_d;
  logic [3:0]            aluop_q,    aluop_d;
  logic                  alusrc1_q,  alusrc1_d;
  logic                  alusrc2_q,  alusrc2_d;
  logic                  regwrite_q, regwrite_d;
  logic                  memread_q,  memread_d;

  logic [XLEN-1:0]       fwd_rs1;
  logic [XLEN-1:0]       fwd_rs2;
  logic                  hazard_rs1;
  logic                  hazard_rs2;

  // Load-use hazard: a load in EX whose rd is read by the instruction in ID.
  // Suppressed during flush because the ID instruction is being discarded.
  always_comb begin
    hazard_rs1     = id_uses_rs1 && (id_rs1_addr == rd_addr_q);
    hazard_rs2     = id_uses_rs2 && (id_rs2_addr == rd_addr_q);
    load_use_stall = valid_q && memread_q && (rd_addr_q != '0) && id_valid
                     && (hazard_rs1 || hazard_rs2) && !flush;
  end

  // Next-state: flush > stall > load-use bubble > capture.
  always_comb begin
    valid_d    = valid_q;
    pc_d       = pc_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    imm_d      = imm_q;
    rs1_addr_d = rs1_addr_q;
    rs2_addr_d = rs2_addr_q;
    rd_addr_d  = rd_addr_q;
    aluop_d    = aluop_q;
    alusrc1_d  = alusrc1_q;
    alusrc2_d  = alusrc2_q;
    regwrite_d = regwrite_q;
    memread_d  = memread_q;
    if (flush || (!stall && load_use_stall)) begin
      // Bubble: every field zero so the ALU sees ADD 0+0.
      valid_d    = 1'b0;
      pc_d       = '0;
      rs1_data_d = '0;
      rs2_data_d = '0;
      imm_d      = '0;
      rs1_addr_d = '0;
      rs2_addr_d = '0;
      rd_addr_d  = '0;
      aluop_d    = '0;
      alusrc1_d  = 1'b0;
      alusrc2_d  = 1'b0;
      regwrite_d = 1'b0;
      memread_d  = 1'b0;
    end else if (!stall) begin
      valid_d    = id_valid;
      pc_d       = id_pc;
      rs1_data_d = id_rs1_data;
      rs2_data_d = id_rs2_data;
      imm_d      = id_imm;
      rs1_addr_d = id_rs1_addr;
      rs2_addr_d = id_rs2_addr;
      rd_addr_d  = id_rd_addr;
      aluop_d    = id_aluop;
      alusrc1_d  = id_alusrc1;
      alusrc2_d  = id_alusrc2;
      regwrite_d = id_regwrite;
      memread_d  = id_memread;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rs1_addr_q <= '0;
      rs2_addr_q <= '0;
      rd_addr_q  <= '0;
      aluop_q    <= '0;
      alusrc1_q  <= 1'b0;
      alusrc2_q  <= 1'b0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      pc_q       <= pc_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      rs1_addr_q <= rs1_addr_d;
      rs2_addr_q <= rs2_addr_d;
      rd_addr_q  <= rd_addr_d;
      aluop_q    <= aluop_d;
      alusrc1_q  <= alusrc1_d;
      alusrc2_q  <= alusrc2_d;
      regwrite_q <= regwrite_d;
      memread_q  <= memread_d;
    end
  end

  // x0 always reads as zero and is never a forwarding target; EX/MEM is
  // the younger producer so it wins over MEM/WB.
  always_comb begin
    if (rs1_addr_q == '0)
      fwd_rs1 = '0;
    else if (exmem_regwrite && (exmem_rd == rs1_addr_q))
      fwd_rs1 = exmem_result;
    else if (memwb_regwrite && (memwb_rd == rs1_addr_q))
      fwd_rs1 = memwb_result;
    else
      fwd_rs1 = rs1_data_q;

    if (rs2_addr_q == '0)
      fwd_rs2 = '0;
    else if (exmem_regwrite && (exmem_rd == rs2_addr_q))
      fwd_rs2 = exmem_result;
    else if (memwb_regwrite && (memwb_rd == rs2_addr_q))
      fwd_rs2 = memwb_result;
    else
      fwd_rs2 = rs2_data_q;
  end

  always_comb begin
    alu_in1       = alusrc1_q ? pc_q  : fwd_rs1;
    alu_in2       = alusrc2_q ? imm_q : fwd_rs2;
    aluop         = aluop_q;
    ex_valid      = valid_q;
    ex_pc         = pc_q;
    ex_rd_addr    = rd_addr_q;
    ex_regwrite   = regwrite_q && valid_q;
    ex_memread    = memread_q && valid_q;
    ex_store_data = fwd_rs2;
  end

endmodule
